// File: rtl/lsu_if.sv
// Request/response and dmem port bundle for the load/store unit.
// slave = the lsu side; master = datapath plus dmem side.
interface lsu_if;
    localparam int XLEN = 32;

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            resp_valid;
    logic            resp_err;
    logic [XLEN-1:0] resp_rdata;

    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, dmem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output dmem_addr, dmem_wdata, dmem_we
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, dmem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  dmem_addr, dmem_wdata, dmem_we
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: byte/half/word RISC-V loads and stores over a word-only dmem.
// Sub-word stores are read-modify-write. Define LSU_MISALIGN_CHECK_EN to reject misaligned accesses.

// One byte lane of the read-modify-write merge.
module lsu_lane #(
    parameter int VEC_W = 8
) (
    input  logic             sel,
    input  logic [VEC_W-1:0] new_byte,
    input  logic [VEC_W-1:0] old_byte,
    output logic [VEC_W-1:0] out_byte
);
    assign out_byte = sel ? new_byte : old_byte;
endmodule

module lsu (
    input logic  clk,
    input logic  rst_n,
    lsu_if.slave bus
);
    localparam int XLEN      = 32;
    localparam int VEC_W     = 8;
    localparam int NUM_LANES = XLEN / VEC_W;

    typedef enum logic [1:0] {IDLE, LOAD, RMW} state_t;

    typedef struct packed {
        logic [2:0]      funct3;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } req_t;

    state_t state, state_n;
    req_t   in_req, lat_req, cur;
    logic   accept, bad_f3, misalign, is_half, is_word, latch;

    logic            resp_valid_n, resp_err_n;
    logic [XLEN-1:0] resp_rdata_n, load_ext;

    logic [NUM_LANES-1:0][VEC_W-1:0] rd_lanes, mrg_lanes, new_lanes;
    logic [NUM_LANES-1:0]            lane_sel;
    logic [VEC_W-1:0]                byte_sel;
    logic [2*VEC_W-1:0]              half_sel;

    // ---------------- request decode ----------------
    assign is_half = (bus.req_funct3[1:0] == 2'b01);
    assign is_word = (bus.req_funct3[1:0] == 2'b10);

    always_comb begin
        if (bus.req_we) bad_f3 = (bus.req_funct3 > 3'b010);
        else            bad_f3 = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
    end

`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign = (is_half & bus.req_addr[0]) | (is_word & (|bus.req_addr[1:0]));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        in_req.funct3 = bus.req_funct3;
        in_req.wdata  = bus.req_wdata;
        in_req.addr   = bus.req_addr;
`ifndef LSU_MISALIGN_CHECK_EN
        // Without the check, misaligned accesses silently snap to natural alignment.
        if (is_half) in_req.addr[0]   = 1'b0;
        if (is_word) in_req.addr[1:0] = 2'b00;
`endif
    end

    assign bus.req_ready = (state == IDLE) & rst_n;
    assign accept        = bus.req_valid & bus.req_ready;
    assign cur           = (state == IDLE) ? in_req : lat_req;

    // ---------------- load extraction ----------------
    assign rd_lanes = bus.dmem_rdata;
    assign byte_sel = rd_lanes[lat_req.addr[1:0]];
    assign half_sel = lat_req.addr[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];

    always_comb begin
        case (lat_req.funct3)
            3'b000:  load_ext = {{(XLEN-VEC_W){byte_sel[VEC_W-1]}}, byte_sel};
            3'b001:  load_ext = {{(XLEN-2*VEC_W){half_sel[2*VEC_W-1]}}, half_sel};
            3'b100:  load_ext = {{(XLEN-VEC_W){1'b0}}, byte_sel};
            3'b101:  load_ext = {{(XLEN-2*VEC_W){1'b0}}, half_sel};
            default: load_ext = bus.dmem_rdata;
        endcase
    end

    // ---------------- sub-word merge ----------------
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        localparam logic [1:0] LANE = 2'(k);
        assign lane_sel[k]  = lat_req.funct3[0] ? (LANE[1] == lat_req.addr[1])
                                                : (LANE == lat_req.addr[1:0]);
        assign new_lanes[k] = lat_req.funct3[0] ? lat_req.wdata[VEC_W*(k%2) +: VEC_W]
                                                : lat_req.wdata[VEC_W-1:0];
        lsu_lane #(.VEC_W(VEC_W)) u_lane (
            .sel      (lane_sel[k]),
            .new_byte (new_lanes[k]),
            .old_byte (rd_lanes[k]),
            .out_byte (mrg_lanes[k])
        );
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_n        = state;
        latch          = 1'b0;
        bus.dmem_we    = 1'b0;
        bus.dmem_addr  = {cur.addr[XLEN-1:2], 2'b00};
        bus.dmem_wdata = cur.wdata;
        resp_valid_n   = 1'b0;
        resp_err_n     = 1'b0;
        resp_rdata_n   = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bad_f3 | misalign) begin
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                    end else if (!bus.req_we) begin
                        latch   = 1'b1;
                        state_n = LOAD;
                    end else if (is_word) begin
                        bus.dmem_we  = 1'b1;
                        resp_valid_n = 1'b1;
                    end else begin
                        latch   = 1'b1;
                        state_n = RMW;
                    end
                end
            end
            LOAD: begin
                resp_valid_n = 1'b1;
                resp_rdata_n = load_ext;
                state_n      = IDLE;
            end
            RMW: begin
                bus.dmem_we    = 1'b1;
                bus.dmem_wdata = mrg_lanes;
                resp_valid_n   = 1'b1;
                state_n        = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            lat_req        <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
        end else begin
            state          <= state_n;
            if (latch) lat_req <= in_req;
            bus.resp_valid <= resp_valid_n;
            bus.resp_err   <= resp_err_n;
            bus.resp_rdata <= resp_rdata_n;
        end
    end
endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed test-plan steps, then random traffic against a byte-level memory model.
module tb_lsu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_if bus();
    lsu dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;

    // dmem stub: word array, registered read on non-write cycles
    logic [31:0] mem [0:255];
    logic        mem_clr = 1'b1;
    int          wr_cnt = 0;
    int          misalign_cnt = 0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (bus.dmem_we) begin
            mem[bus.dmem_addr[9:2]] <= bus.dmem_wdata;
            wr_cnt <= wr_cnt + 1;
        end else begin
            bus.dmem_rdata <= mem[bus.dmem_addr[9:2]];
        end
        if (bus.dmem_addr[1:0] != 2'b00) misalign_cnt <= misalign_cnt + 1;
    end

    // reference: flat byte memory
    logic [7:0] ref_mem [0:1023];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int ref_size(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic ref_bad(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic bad;
        if (we) bad = (f3 > 3'd2);
        else    bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
`ifdef LSU_MISALIGN_CHECK_EN
        if (!bad && (a % ref_size(f3)) != 0) bad = 1'b1;
`endif
        return bad;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int          sz, base;
        longint      v;
        sz   = ref_size(f3);
        base = int'(a[9:0]) - (int'(a[9:0]) % sz);
        v    = 0;
        for (int i = 0; i < sz; i++) v = v + (longint'(ref_mem[base+i]) << (8*i));
        if (!f3[2] && sz < 4 && v >= (longint'(1) << (8*sz-1))) v = v - (longint'(1) << (8*sz));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int sz, base;
        sz   = ref_size(f3);
        base = int'(a[9:0]) - (int'(a[9:0]) % sz);
        for (int i = 0; i < sz; i++) ref_mem[base+i] = 8'(wd >> (8*i));
    endtask

    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input string tag, output logic [31:0] got);
        logic        ebad;
        logic [31:0] exp_rd;
        int          exp_lat, lat, w0;
        ebad    = ref_bad(we, f3, a);
        exp_rd  = (ebad || we) ? 32'h0 : ref_load(f3, a);
        exp_lat = (ebad || (we && f3 == 3'd2)) ? 1 : 2;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        w0 = wr_cnt;
        @(posedge clk);
        #1;
        // scramble request fields to prove they were latched at accept
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < 6) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_err"}, 32'(bus.resp_err), 32'(ebad));
        chk({tag, "_rdata"}, bus.resp_rdata, exp_rd);
        chk({tag, "_writes"}, 32'(wr_cnt - w0), (ebad || !we) ? 32'd0 : 32'd1);
        got = bus.resp_rdata;
        if (!ebad && we) ref_store(f3, a, wd);
    endtask

    logic [31:0] r, pre;
    int          w_rst;

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        // present a SW during reset: nothing may reach dmem
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h40;
        bus.req_wdata  = 32'h11111111;
        repeat (3) @(posedge clk);
        #1;
        mem_clr = 1'b0;
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_dmem_we", 32'(bus.dmem_we), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        do_op(1'b1, 3'b010, 32'h40, 32'hDEADBEEF, "sw40", r);
        do_op(1'b0, 3'b010, 32'h40, 32'h0, "lw40a", r);
        chk("lw40a_val", r, 32'hDEADBEEF);
        do_op(1'b1, 3'b000, 32'h41, 32'hFFFFFF12, "sb41", r);
        do_op(1'b0, 3'b010, 32'h40, 32'h0, "lw40b", r);
        chk("lw40b_val", r, 32'hDEAD12EF);
        do_op(1'b0, 3'b000, 32'h43, 32'h0, "lb43", r);
        chk("lb43_val", r, 32'hFFFFFFDE);
        do_op(1'b0, 3'b100, 32'h43, 32'h0, "lbu43", r);
        chk("lbu43_val", r, 32'h000000DE);
        do_op(1'b1, 3'b001, 32'h42, 32'h12348001, "sh42", r);
        do_op(1'b0, 3'b001, 32'h42, 32'h0, "lh42", r);
        chk("lh42_val", r, 32'hFFFF8001);
        do_op(1'b0, 3'b101, 32'h42, 32'h0, "lhu42", r);
        chk("lhu42_val", r, 32'h00008001);
        do_op(1'b0, 3'b010, 32'h40, 32'h0, "lw40c", r);
        chk("lw40c_val", r, 32'h800112EF);
        do_op(1'b0, 3'b010, 32'h41, 32'h0, "lw41", r);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("lw41_val", r, 32'h0);
`else
        chk("lw41_val", r, 32'h800112EF);
`endif
        do_op(1'b0, 3'b011, 32'h40, 32'h0, "ld_f3_011", r);
        do_op(1'b1, 3'b100, 32'h40, 32'hCAFEF00D, "st_f3_100", r);
        do_op(1'b0, 3'b010, 32'h40, 32'h0, "lw40d", r);
        chk("lw40d_val", r, 32'h800112EF);

        // SB @0x50 with reset pulsed during the RMW write cycle
        do_op(1'b1, 3'b010, 32'h50, 32'h76543210, "sw50", r);
        pre = ref_load(3'b010, 32'h50);
        w_rst = wr_cnt;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h50;
        bus.req_wdata  = 32'h000000A5;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmw_rst_dmem_we", 32'(bus.dmem_we), 32'd0);
        chk("rmw_rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rmw_rst_resp", 32'(bus.resp_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("rmw_rst_resp2", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rmw_rst_resp3", 32'(bus.resp_valid), 32'd0);
        chk("rmw_rst_ready_back", 32'(bus.req_ready), 32'd1);
        chk("rmw_rst_nowrite", 32'(wr_cnt - w_rst), 32'd0);
        do_op(1'b0, 3'b010, 32'h50, 32'h0, "lw50", r);
        chk("lw50_val", r, pre);

        // random traffic against the reference model
        for (int n = 0; n < 300; n++) begin
            do_op(1'($urandom), 3'($urandom), {22'h0, 10'($urandom)}, $urandom, "rnd", r);
        end

        chk("dmem_addr_aligned", 32'(misalign_cnt), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting between the datapath's memory stage and the word-only `dmem` block. It accepts RISC-V byte, halfword and word loads and stores, and sign- or zero-extends load data. Sub-word stores become a read-modify-write sequence, because `dmem` has a single whole-word write enable. All `dmem` traffic goes through this block; the datapath never drives `dmem` directly.

## Interface
- `XLEN`, 32 (from `constants.vh`, not overridable), data/address width.
- `clk` in 1: the one clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; high only in IDLE and while `rst_n` high.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- `req_addr` in XLEN: byte address.
- `req_wdata` in XLEN: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse; no backpressure.
- `resp_rdata` out XLEN: extended load data; 0 for stores and errors.
- `resp_err` out 1: request rejected, no memory side effect.
- `dmem_addr` out XLEN: word-aligned byte address to `dmem` (low 2 bits 0).
- `dmem_wdata` out XLEN: full word to write.
- `dmem_we` out 1: write enable.
- `dmem_rdata` in XLEN: `dmem` registered read data, valid one cycle after a non-write access.

## Operation
- States: IDLE, LOAD, RMW. Accept = `req_valid & req_ready`.
- In IDLE, the `dmem` port is driven combinationally from the request. In other states, it is driven from latched request registers.
- Byte lanes are little-endian: byte k = bits [8k+7:8k], k = addr[1:0]. Halfword lane = addr[1].
- **Load accept:** `dmem_we`=0, IDLE→LOAD.
- **LOAD:** select the lane from `dmem_rdata`. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word. Register the result into `resp_rdata`, pulse `resp_valid`, go to IDLE.
- **SW accept:** `dmem_we`=1 and `dmem_wdata`=`req_wdata` in the accept cycle. Stay in IDLE. `resp_valid` pulses the next cycle.
- **SB/SH accept:** `dmem_we`=0 (read), IDLE→RMW.
- **RMW:** merge `req_wdata[7:0]` or `[15:0]` into the selected lane of `dmem_rdata`. Other lanes are unchanged. Drive `dmem_we`=1 with the merged word, pulse `resp_valid` next cycle, go to IDLE.
- **Errors:**
  - Invalid funct3: loads 011/110/111; stores with funct3 > 010.
  - Misaligned access (when the check is compiled in): LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0.
  - Error behaviour: `dmem_we`=0, stay in IDLE, next cycle `resp_valid`=1, `resp_err`=1, `resp_rdata`=0.
- `resp_err`=0 on every successful response.

## Timing
- Latency from accept cycle to `resp_valid`:
  - Loads: 2 cycles.
  - SW: 1 cycle.
  - SB/SH: 2 cycles.
  - Errors: 1 cycle.
- `req_ready` is high in the cycle `resp_valid` is high. A new request may be accepted then, so back-to-back operation is supported.
- Throughput:
  - One SW or error per cycle.
  - One load or sub-word store per 2 cycles.
- Reset values: state IDLE; `resp_valid`=0, `resp_err`=0, `resp_rdata`=0; `req_ready`=0 and `dmem_we`=0 while `rst_n` is low.
- Reset mid-operation:
  - Reset asserted in LOAD or RMW aborts with no response.
  - Reset asserted during an RMW write cycle is asynchronous, so `dmem_we` drops and the word is not written.
- `req_*` inputs are sampled only at accept and latched. They may change afterwards.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - Misaligned halfword/word accesses produce an error response with no `dmem` access.
- Not defined:
  - No alignment check.
  - The address is forced to natural alignment: addr[0] cleared for halfwords, addr[1:0] cleared for words.
  - The access proceeds normally.
  - `resp_err` is raised only for invalid funct3.

## Test plan
- SW 0xDEADBEEF @0x40, then LW @0x40 → `resp_rdata`=0xDEADBEEF, `resp_err`=0, 2-cycle load latency.
- After the above: SB 0x12 @0x41, then LW @0x40 → 0xDEAD12EF. LB @0x43 → 0xFFFFFFDE. LBU @0x43 → 0x000000DE.
- SH 0x8001 @0x42, then LH @0x42 → 0xFFFF8001. LHU @0x42 → 0x00008001. Word @0x40 → 0x800112EF.
- LW @0x41:
  - With macro: `resp_err`=1, `resp_rdata`=0 one cycle after accept, no `dmem_we`.
  - Without macro: returns the word @0x40.
- Request with funct3=011, `req_we`=0 → `resp_err`=1 in both builds. Store funct3=100 → `resp_err`=1 and memory unchanged.
- SB @0x50 with `rst_n` pulsed low in the RMW cycle → no `resp_valid`, `req_ready` returns high after reset, and a later LW @0x50 reads the pre-store value.
